// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: time-multiplexed seven-segment scan driver for N_DIGITS
// common-anode digits.
//
// A frame of segment patterns is captured into a pending buffer by a load
// strobe. It is promoted to the active (displayed) buffer only at the scan
// wrap, so a frame never changes part-way through a scan. Each digit slot
// lasts 2^DIV_LOG2 clocks. The top BW prescaler bits are compared against
// 'bright' to PWM the digit. The first cycle of every slot is dark, so the
// previous digit's segments never ghost onto the next anode.
//
// Optional feature: define SSEG_SCAN_MUX_BLINK_EN to add the blink_mask input.
// Masked digits then go dark for 2^BLINK_LOG2 frames out of every
// 2^(BLINK_LOG2+1) frames.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset (0 = reset)
//   din         8*N_DIGITS segment patterns, active-low; byte k -> digit k
//   load        one-cycle strobe capturing din as the next frame
//   blank_mask  1 = digit k forced dark (sampled live)
//   blink_mask  (SSEG_SCAN_MUX_BLINK_EN only) 1 = digit k blinks
//   bright      brightness level, 0 = dimmest, all-ones = full (sampled live)
//   an          anode enables, active-low, at most one low
//   sseg        segment drive, active-low
//   busy        a loaded frame is waiting for the next scan wrap
//   frame_tick  one-cycle pulse in the cycle after the scan wraps to digit 0

module sseg_scan_mux #(
    parameter int N_DIGITS   = 8,
    parameter int DIV_LOG2   = 10,
    parameter int BW         = 4,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*N_DIGITS-1:0] din,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   blank_mask,
`ifdef SSEG_SCAN_MUX_BLINK_EN
    input  logic [N_DIGITS-1:0]   blink_mask,
`endif
    input  logic [BW-1:0]         bright,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  busy,
    output logic                  frame_tick
);

    localparam int IW = $clog2(N_DIGITS);

    logic [DIV_LOG2-1:0] pcnt;
    logic [IW-1:0]       idx;
    logic                slot_end;
    logic                frame_wrap;
    logic [7:0]          active  [N_DIGITS];
    logic [7:0]          pending [N_DIGITS];
    logic [N_DIGITS-1:0] blink_off;
    logic [N_DIGITS-1:0] one_hot;
    logic                digit_on;

    assign slot_end   = &pcnt;
    assign frame_wrap = slot_end && (idx == IW'(N_DIGITS - 1));

    // Scan timing: prescaler, digit index, frame pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt       <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            pcnt       <= pcnt + 1'b1;
            frame_tick <= frame_wrap;
            if (slot_end) begin
                idx <= frame_wrap ? '0 : idx + 1'b1;
            end
        end
    end

    // Double buffer. A load that coincides with the wrap goes straight to
    // active. Whatever was pending is stale at that point and is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                active[k]  <= 8'hFF;
                pending[k] <= 8'hFF;
            end
            busy <= 1'b0;
        end else if (load && frame_wrap) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                active[k] <= din[8*k +: 8];
            end
            busy <= 1'b0;
        end else if (load) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                pending[k] <= din[8*k +: 8];
            end
            busy <= 1'b1;
        end else if (frame_wrap && busy) begin
            active <= pending;
            busy   <= 1'b0;
        end
    end

`ifdef SSEG_SCAN_MUX_BLINK_EN
    logic [BLINK_LOG2-1:0] fcnt;
    logic                  blink_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            fcnt <= fcnt + 1'b1;
            if (&fcnt) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    assign blink_off = blink_mask & {N_DIGITS{blink_phase}};
`else
    assign blink_off = '0;
`endif

    // pcnt == 0 is the dead cycle. Otherwise the slot stays lit while the
    // top BW prescaler bits have not passed the brightness level.
    assign digit_on = (pcnt != '0)
                   && (pcnt[DIV_LOG2-1 -: BW] <= bright)
                   && !blank_mask[idx]
                   && !blink_off[idx];

    assign one_hot = N_DIGITS'(1) << idx;

    // Output register: one cycle behind the counter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an   <= '1;
            sseg <= 8'hFF;
        end else begin
            an   <= digit_on ? ~one_hot : '1;
            sseg <= digit_on ? active[idx] : 8'hFF;
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux with N_DIGITS=4, DIV_LOG2=3, BW=2 and
// BLINK_LOG2=1. A slot is 8 clocks and a frame is 32 clocks.
//
// Before every clock edge, a behavioural model derives the expected
// registered outputs from its own cycle count and load history. It pushes
// them to a scoreboard queue. The entry is popped and compared after the edge.
module tb_sseg_scan_mux;

    localparam int ND = 4;
    localparam int DL = 3;
    localparam int BWD = 2;
    localparam int BL = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   din;
    logic          load;
    logic [3:0]    blank_mask;
    logic [3:0]    blink_mask;
    logic [1:0]    bright;
    logic [3:0]    an;
    logic [7:0]    sseg;
    logic          busy;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    sseg_scan_mux #(
        .N_DIGITS(ND), .DIV_LOG2(DL), .BW(BWD), .BLINK_LOG2(BL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .load(load),
        .blank_mask(blank_mask),
`ifdef SSEG_SCAN_MUX_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .bright(bright),
        .an(an),
        .sseg(sseg),
        .busy(busy),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
        logic       busy;
        logic       tick;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int          mn;
    logic [31:0] m_active;
    logic [31:0] m_pending;
    logic        m_busy;
    int          m_fcnt;
    logic        m_phase;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mn        = 0;
        m_active  = 32'hFFFF_FFFF;
        m_pending = 32'hFFFF_FFFF;
        m_busy    = 1'b0;
        m_fcnt    = 0;
        m_phase   = 1'b0;
        sb.delete();
    endtask

    // One clock: predict, push, clock, pop, compare
    task automatic step();
        exp_t e;
        exp_t g;
        int   pc;
        int   id;
        logic fw;
        logic boff;
        logic on;
        pc   = mn % 8;
        id   = (mn / 8) % 4;
        fw   = ((mn % 32) == 31);
`ifdef SSEG_SCAN_MUX_BLINK_EN
        boff = blink_mask[id] & m_phase;
`else
        boff = 1'b0;
`endif
        on = (pc != 0) && ((pc >> 1) <= int'(bright)) && !blank_mask[id] && !boff;
        e.an   = on ? ~(4'b0001 << id) : 4'hF;
        e.sseg = on ? m_active[id*8 +: 8] : 8'hFF;
        if (load && fw) begin
            m_active = din;
            m_busy   = 1'b0;
        end else if (load) begin
            m_pending = din;
            m_busy    = 1'b1;
        end else if (fw && m_busy) begin
            m_active = m_pending;
            m_busy   = 1'b0;
        end
        if (fw) begin
            if (m_fcnt == (1 << BL) - 1) m_phase = ~m_phase;
            m_fcnt = (m_fcnt + 1) % (1 << BL);
        end
        e.busy = m_busy;
        e.tick = fw;
        mn++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("sb_an",   32'(an),         32'(g.an));
        chk("sb_sseg", 32'(sseg),       32'(g.sseg));
        chk("sb_busy", 32'(busy),       32'(g.busy));
        chk("sb_tick", 32'(frame_tick), 32'(g.tick));
    endtask

    initial begin
        int first_tick;
        int c0;
        int c3;
        int lit;
        int seen11;
        int seen22;
        int seen33;
        int exp_d0;

        reset      = 1'b0;
        load       = 1'b0;
        din        = '0;
        bright     = 2'd3;
        blank_mask = 4'hF;
        blink_mask = 4'h0;
        model_reset();

        // Reset held: outputs dark
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_an",   32'(an),         32'hF);
            chk("rst_sseg", 32'(sseg),       32'hFF);
            chk("rst_busy", 32'(busy),       32'h0);
            chk("rst_tick", 32'(frame_tick), 32'h0);
        end

        // Release with load idle, all digits blanked
        reset      = 1'b1;
        first_tick = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            chk("idle_an",   32'(an),   32'hF);
            chk("idle_sseg", 32'(sseg), 32'hFF);
            if (frame_tick && first_tick < 0) first_tick = i;
        end
        chk("first_tick_edge", 32'(first_tick), 32'd32);

        // Load a frame mid-scan
        blank_mask = 4'h0;
        din  = 32'hC0F9A4B0;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("busy_after_load", 32'(busy), 32'h1);
        while (mn < 64) step();
        chk("busy_after_wrap", 32'(busy), 32'h0);
        c0 = 0;
        c3 = 0;
        repeat (32) begin
            step();
            if (an == 4'b1110 && sseg == 8'hB0) c0++;
            if (an == 4'b0111 && sseg == 8'hC0) c3++;
        end
        chk("digit0_lit", 32'(c0), 32'd7);
        chk("digit3_lit", 32'(c3), 32'd7);

        // Brightness 0 then 2
        bright = 2'd0;
        lit = 0;
        repeat (32) begin step(); if (an != 4'hF) lit++; end
        chk("bright0_lit", 32'(lit), 32'd4);
        bright = 2'd2;
        lit = 0;
        repeat (32) begin step(); if (an != 4'hF) lit++; end
        chk("bright2_lit", 32'(lit), 32'd20);
        bright = 2'd3;

        // Two loads while busy, then a load on the wrap
        seen11 = 0;
        seen22 = 0;
        seen33 = 0;
        repeat (3) step();
        din = 32'h11111111; load = 1'b1; step(); load = 1'b0;
        step();
        din = 32'h22222222; load = 1'b1; step(); load = 1'b0;
        chk("busy_overwrite", 32'(busy), 32'h1);
        while (mn < 192) begin step(); if (sseg == 8'h11) seen11++; end
        while (mn < 223) begin
            step();
            if (sseg == 8'h11) seen11++;
            if (sseg == 8'h22) seen22++;
        end
        din = 32'h33333333; load = 1'b1; step(); load = 1'b0;
        if (sseg == 8'h22) seen22++;
        chk("busy_coincident", 32'(busy), 32'h0);
        repeat (32) begin
            step();
            if (sseg == 8'h11) seen11++;
            if (sseg == 8'h33) seen33++;
        end
        chk("never_11", 32'(seen11), 32'd0);
        chk("frame_22", 32'(seen22), 32'd28);
        chk("frame_33", 32'(seen33), 32'd28);

        // Blank digit 2
        blank_mask = 4'b0100;
        c0  = 0;
        lit = 0;
        repeat (32) begin
            step();
            if (an[2] == 1'b0) c0++;
            if (an != 4'hF) lit++;
        end
        chk("blank_an2", 32'(c0), 32'd0);
        chk("blank_others", 32'(lit), 32'd21);
        blank_mask = 4'h0;

        // Pending frame then asynchronous reset mid-frame
        din = 32'h44444444; load = 1'b1; step(); load = 1'b0;
        step();
        chk("busy_pre_reset", 32'(busy), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_an",   32'(an),   32'hF);
        chk("async_sseg", 32'(sseg), 32'hFF);
        chk("async_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        chk("async_hold_an", 32'(an), 32'hF);
        reset = 1'b1;
        model_reset();

        // Six frames after reset with blink requested on digit 0. The
        // pending 44 frame is gone, so digit 0 shows FF when lit.
        blink_mask = 4'b0001;
        for (int f = 0; f < 6; f++) begin
            c0 = 0;
            repeat (32) begin
                step();
                if (an == 4'b1110 && sseg == 8'hFF) c0++;
            end
`ifdef SSEG_SCAN_MUX_BLINK_EN
            exp_d0 = (f == 2 || f == 3) ? 0 : 7;
`else
            exp_d0 = 7;
`endif
            chk($sformatf("blink_frame%0d", f), 32'(c0), 32'(exp_d0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
- Parametrised time-multiplexed seven-segment scan driver; successor to the fixed 8-anode/16-input display mux.
- Drives N_DIGITS common-anode digits from a flattened segment-pattern bus.
- Adds a double-buffered frame load (no tearing), PWM brightness, per-digit blanking and an anti-ghost dead cycle.
- Sits between the display-formatting logic and the board anode/segment pins.

Parameters:
- N_DIGITS, 8, number of digits/anodes; must be >= 2.
- DIV_LOG2, 10, log2 of clk cycles per digit slot; must be >= BW.
- BW, 4, brightness control width.
- BLINK_LOG2, 5, log2 of frames per blink half-period (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- din  in  8*N_DIGITS  segment patterns, active-low; byte k drives digit k (bit 7 = dp).
- load  in  1  single-cycle strobe that captures din as the next frame.
- blank_mask  in  N_DIGITS  1 = digit k forced dark.
- bright  in  BW  brightness level; 0 = dimmest, all-ones = full.
- an  out  N_DIGITS  anode enables, active-low, at most one low.
- sseg  out  8  segment drive, active-low.
- busy  out  1  a loaded frame is pending display.
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (async assert, sync release) sets: an = all 1s, sseg = 8'hFF, active buffer = all 8'hFF, pending buffer = all 8'hFF, busy = 0, frame_tick = 0, prescaler = 0, digit index = 0.
- Prescaler pcnt (DIV_LOG2 bits) increments every cycle and wraps naturally. slot_end = (pcnt == all-ones).
- Digit index idx advances on slot_end and wraps from N_DIGITS-1 to 0. When the wrap occurs, frame_wrap = 1.
- frame_tick is registered: it is high in the cycle after frame_wrap.
- Frame buffering:
  - load with frame_wrap = 0: pending <= din and busy <= 1. A load while busy overwrites pending; only the last load is kept.
  - frame_wrap with busy = 1: active <= pending and busy <= 0.
  - load and frame_wrap in the same cycle: active <= din directly, busy <= 0, and any older pending data is discarded.
- Digit-on condition, computed from the current pcnt/idx: on = (pcnt != 0) AND (pcnt[DIV_LOG2-1 -: BW] <= bright) AND NOT blank_mask[idx] AND NOT blink_off[idx].
- Outputs are registered, with 1-cycle latency from the counter state:
  - an <= on ? ~(1 << idx) : all 1s.
  - sseg <= on ? active[idx] : 8'hFF.
- pcnt == 0 is always dark (anti-ghost dead cycle). With bright = all-ones the duty is (2^DIV_LOG2 - 1)/2^DIV_LOG2. With bright = 0 the duty is (2^(DIV_LOG2-BW) - 1)/2^DIV_LOG2.
- blank_mask and bright are sampled live every cycle; they are not buffered.
- Reset asserted mid-frame immediately forces all outputs dark and discards pending data. After release, scanning restarts at digit 0.

Optional Feature:
- Macro: SSEG_SCAN_MUX_BLINK_EN.
- Defined:
  - Adds input port blink_mask[N_DIGITS-1:0].
  - A BLINK_LOG2-bit frame counter increments on frame_wrap. blink_phase toggles each time the counter wraps. Both reset to 0.
  - blink_off[k] = blink_mask[k] AND blink_phase.
- Undefined: no blink_mask port, no frame counter, blink_off = 0.

Test Plan (N_DIGITS=4, DIV_LOG2=3, BW=2, BLINK_LOG2=1):
- Reset held, then released with load idle -> an=4'b1111 and sseg=8'hFF every cycle. First frame_tick occurs 33 cycles after release (32 cycles + 1 register).
- load din=32'hC0F9A4B0, bright=3, blank_mask=0 -> busy=1 until the next wrap. Then digit 0 shows an=4'b1110, sseg=8'hB0 for 7 of 8 cycles, and digit 3 shows an=4'b0111, sseg=8'hC0.
- bright=0 -> each slot is lit exactly 1 cycle (pcnt=1). bright=2 -> lit for pcnt 1..5.
- Two loads while busy (32'h11111111, then 32'h22222222); load coincident with frame_wrap (32'h33333333) -> only 22.. and 33.. frames ever appear; busy=0 after the coincident load.
- blank_mask=4'b0100 -> an[2] stays high for the whole digit-2 slot and sseg=8'hFF in that slot; the other digits are unaffected.
- With SSEG_SCAN_MUX_BLINK_EN and blink_mask=4'b0001 -> digit 0 is dark during frames 2-3 and lit during frames 0-1 and 4-5. Without the macro, digit 0 is never dark.
